// File: rtl/rebeccargb_universal_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rebeccargb_universal_decoder
// Purpose  : Registered 4-bit multi-mode decoder (7-seg BCD/hex, one-hot,
//            thermometer, BCD, Gray, pass-through) for the TinyTapeout harness.
//            Define UDEC_TAIL_EN to select the tailed 7-segment font.
// Revision : 1.0 - initial release
// ============================================================================
module rebeccargb_universal_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

`ifdef UDEC_TAIL_EN
    localparam logic [6:0] c_FONT_6 = 7'h7D;
    localparam logic [6:0] c_FONT_7 = 7'h27;
    localparam logic [6:0] c_FONT_9 = 7'h6F;
`else
    localparam logic [6:0] c_FONT_6 = 7'h7C;
    localparam logic [6:0] c_FONT_7 = 7'h07;
    localparam logic [6:0] c_FONT_9 = 7'h67;
`endif

    localparam logic [2:0] c_M_BCD7   = 3'd0;
    localparam logic [2:0] c_M_HEX7   = 3'd1;
    localparam logic [2:0] c_M_OH_HI  = 3'd2;
    localparam logic [2:0] c_M_OH_LO  = 3'd3;
    localparam logic [2:0] c_M_BIN2BCD = 3'd4;
    localparam logic [2:0] c_M_GRAY   = 3'd5;
    localparam logic [2:0] c_M_THERM  = 3'd6;
    localparam logic [2:0] c_M_PASS   = 3'd7;

    function automatic logic [6:0] f_font(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = c_FONT_6;
            4'h7:    seg = c_FONT_7;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = c_FONT_9;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    logic [3:0]  w_d;
    logic [2:0]  w_mode;
    logic        w_lt;
    logic [15:0] w_onehot;
    logic [7:0]  w_seg7;
    logic        w_unused;
    logic [7:0]  uo_d;
    logic [7:0]  uio_d;
    logic [7:0]  uo_q;
    logic [7:0]  uio_q;

    assign w_d      = ui_in[3:0];
    assign w_mode   = ui_in[6:4];
    assign w_lt     = ui_in[7];
    assign w_onehot = 16'h0001 << w_d;
    assign w_unused = ^uio_in;

    // BCD mode flags D>9 as blank digits with the decimal point lit.
    assign w_seg7 = ((w_mode == c_M_BCD7) && (w_d > 4'd9)) ? 8'h80 : {1'b0, f_font(w_d)};

    always_comb begin
        uo_d  = 8'h00;
        uio_d = 8'h00;
        case (w_mode)
            c_M_BCD7, c_M_HEX7: begin
                if (w_lt) begin
                    uo_d  = 8'hFF;
                    uio_d = 8'h00;
                end else begin
                    uo_d  = w_seg7;
                    uio_d = ~w_seg7;
                end
            end
            c_M_OH_HI:   {uio_d, uo_d} = w_onehot;
            c_M_OH_LO:   {uio_d, uo_d} = ~w_onehot;
            c_M_BIN2BCD: uo_d = (w_d >= 4'd10) ? {4'b0001, w_d - 4'd10} : {4'b0000, w_d};
            c_M_GRAY:    uo_d = {4'b0000, w_d ^ (w_d >> 1)};
            c_M_THERM:   {uio_d, uo_d} = w_onehot - 16'd1;
            c_M_PASS:    uo_d = {4'b0000, w_d};
            default: begin
                uo_d  = 8'h00;
                uio_d = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uo_q  <= 8'h00;
            uio_q <= 8'h00;
        end else if (ena) begin
            uo_q  <= uo_d;
            uio_q <= uio_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = uio_q;
    assign uio_oe  = 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_rebeccargb_universal_decoder.sv
`default_nettype none
// Testbench for rebeccargb_universal_decoder: directed vector table, reset
// corner sequences, latency sweep and randomized run against a reference model.
module tb_rebeccargb_universal_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad = 0;

    rebeccargb_universal_decoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       ena;
        logic [7:0] ui;
        logic [7:0] uo;
        logic [7:0] uio;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   font_t[16];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    // Decode straight from the written rules, using integer arithmetic.
    function automatic logic [15:0] ref_decode(input logic [7:0] ui);
        int d, m, uo, uio, w;
        d = int'(ui[3:0]);
        m = int'(ui[6:4]);
        uo = 0;
        uio = 0;
        if (m <= 1) begin
            if (ui[7]) begin
                uo = 255;
                uio = 0;
            end else begin
                uo = (m == 0 && d > 9) ? 128 : font_t[d];
                uio = 255 - uo;
            end
        end else begin
            w = 0;
            case (m)
                2: w = 2 ** d;
                3: w = 65535 - 2 ** d;
                4: uo = (d / 10) * 16 + (d % 10);
                5: uo = d ^ (d / 2);
                6: w = 2 ** d - 1;
                default: uo = d;
            endcase
            if (m == 2 || m == 3 || m == 6) begin
                uo = w % 256;
                uio = w / 256;
            end
        end
        return {8'(uio), 8'(uo)};
    endfunction

    task automatic step(input logic r, input logic e, input logic [7:0] ui);
        @(negedge clk);
        rst_n = r;
        ena = e;
        ui_in = ui;
        uio_in = 8'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic e, input logic [7:0] ui,
                       input logic [7:0] uo, input logic [7:0] uio, input string nm);
        vecs.push_back(vec_t'{r, e, ui, uo, uio, nm});
    endtask

    initial begin
        logic [15:0] exp16;
        logic [7:0]  exp_uo, exp_uio, prev_ui, nui;

        font_t = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7C, 'h07,
                   'h7F, 'h67, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
`ifdef UDEC_TAIL_EN
        font_t[6] = 'h7D;
        font_t[7] = 'h27;
        font_t[9] = 'h6F;
`endif

        add(1'b0, 1'b1, 8'h03, 8'h00, 8'h00, "reset");
        add(1'b1, 1'b0, 8'h03, 8'h00, 8'h00, "hold_after_reset");
        add(1'b1, 1'b1, 8'h03, 8'h4F, 8'hB0, "bcd_3");
        add(1'b1, 1'b1, 8'h0C, 8'h80, 8'h7F, "bcd_invalid_C");
        add(1'b1, 1'b1, 8'h0A, 8'h80, 8'h7F, "bcd_invalid_A");
        add(1'b1, 1'b1, 8'h08, 8'h7F, 8'h80, "bcd_8");
        add(1'b1, 1'b1, 8'h85, 8'hFF, 8'h00, "lamp_test_bcd");
        add(1'b1, 1'b0, 8'h07, 8'hFF, 8'h00, "hold_ena0");
        add(1'b1, 1'b1, 8'h1B, 8'h7C, 8'h83, "hex_b");
        add(1'b1, 1'b1, 8'h1F, 8'h71, 8'h8E, "hex_F");
        add(1'b1, 1'b1, 8'h9F, 8'hFF, 8'h00, "lamp_test_hex");
`ifdef UDEC_TAIL_EN
        add(1'b1, 1'b1, 8'h16, 8'h7D, 8'h82, "hex_6_tail");
        add(1'b1, 1'b1, 8'h19, 8'h6F, 8'h90, "hex_9_tail");
        add(1'b1, 1'b1, 8'h17, 8'h27, 8'hD8, "hex_7_tail");
        add(1'b1, 1'b1, 8'h09, 8'h6F, 8'h90, "bcd_9_tail");
`else
        add(1'b1, 1'b1, 8'h16, 8'h7C, 8'h83, "hex_6");
        add(1'b1, 1'b1, 8'h19, 8'h67, 8'h98, "hex_9");
        add(1'b1, 1'b1, 8'h17, 8'h07, 8'hF8, "hex_7");
        add(1'b1, 1'b1, 8'h09, 8'h67, 8'h98, "bcd_9");
`endif
        add(1'b1, 1'b1, 8'h2A, 8'h00, 8'h04, "onehot_hi_A");
        add(1'b1, 1'b1, 8'h2F, 8'h00, 8'h80, "onehot_hi_F");
        add(1'b1, 1'b1, 8'h30, 8'hFE, 8'hFF, "onehot_lo_0");
        add(1'b1, 1'b1, 8'h4D, 8'h13, 8'h00, "bin2bcd_D");
        add(1'b1, 1'b1, 8'h49, 8'h09, 8'h00, "bin2bcd_9");
        add(1'b1, 1'b1, 8'h5B, 8'h0E, 8'h00, "gray_B");
        add(1'b1, 1'b1, 8'h69, 8'hFF, 8'h01, "therm_9");
        add(1'b1, 1'b1, 8'h6F, 8'hFF, 8'h7F, "therm_F");
        add(1'b1, 1'b1, 8'hE0, 8'h00, 8'h00, "therm_0_lt_ignored");
        add(1'b1, 1'b1, 8'hFF, 8'h0F, 8'h00, "pass_F_lt_ignored");

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].ena, vecs[i].ui);
            chk({vecs[i].name, "_uo"}, uo_out, vecs[i].uo);
            chk({vecs[i].name, "_uio"}, uio_out, vecs[i].uio);
            chk({vecs[i].name, "_oe"}, uio_oe, 8'hFF);
        end

        // Reset mid-operation, recovery, and reset overriding ena=0.
        step(1'b1, 1'b1, 8'h21);
        chk("pre_reset_uo", uo_out, 8'h02);
        step(1'b0, 1'b1, 8'h21);
        chk("mid_reset_uo", uo_out, 8'h00);
        chk("mid_reset_oe", uio_oe, 8'hFF);
        step(1'b1, 1'b1, 8'h3F);
        chk("post_reset_uo", uo_out, 8'hFF);
        chk("post_reset_uio", uio_out, 8'h7F);
        step(1'b0, 1'b0, 8'h3F);
        chk("reset_over_ena_uo", uo_out, 8'h00);
        chk("reset_over_ena_uio", uio_out, 8'h00);

        // Latency sweep: new input each cycle; outputs must not follow ui_in
        // until the next edge.
        prev_ui = 8'($urandom);
        step(1'b1, 1'b1, prev_ui);
        for (int i = 0; i < 16; i++) begin
            exp16 = ref_decode(prev_ui);
            chk("lat_uo", uo_out, exp16[7:0]);
            chk("lat_uio", uio_out, exp16[15:8]);
            nui = 8'($urandom);
            ui_in = nui;
            #1;
            chk("no_comb_uo", uo_out, exp16[7:0]);
            chk("no_comb_uio", uio_out, exp16[15:8]);
            prev_ui = nui;
            @(posedge clk);
            #1;
        end

        // Randomized run against the reference model.
        step(1'b0, 1'b1, 8'h00);
        exp_uo = 8'h00;
        exp_uio = 8'h00;
        for (int i = 0; i < 400; i++) begin
            logic r, e;
            logic [7:0] u;
            r = ($urandom_range(0, 15) != 0);
            e = ($urandom_range(0, 3) != 0);
            u = 8'($urandom);
            step(r, e, u);
            if (!r) begin
                exp_uo = 8'h00;
                exp_uio = 8'h00;
            end else if (e) begin
                exp16 = ref_decode(u);
                exp_uo = exp16[7:0];
                exp_uio = exp16[15:8];
            end
            chk("rand_uo", uo_out, exp_uo);
            chk("rand_uio", uio_out, exp_uio);
            chk("rand_oe", uio_oe, 8'hFF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
